// File: rtl/id_stage_hz.sv
// id_stage_hz: instruction-decode stage with register file, WB bypass, load-use stall, flush and HALT latch
//  clk, reset (async, active-low)
//  IF side : if_valid, inst -> id_ready
//  WB side : wb_we, wb_addr, wb_data (register-file write port)
//  EX side : ex_ready -> ex_valid, opcode_2_ex, rs_val_2_ex, rt_val_2_ex, imm_2_ex,
//            dest_2_ex, dest_we_2_ex
//  control : flush, halted
module id_stage_hz #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int IMM_W  = 16,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       inst,
  output logic              id_ready,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [5:0]        opcode_2_ex,
  output logic [DATA_W-1:0] rs_val_2_ex,
  output logic [DATA_W-1:0] rt_val_2_ex,
  output logic [DATA_W-1:0] imm_2_ex,
  output logic [AW-1:0]     dest_2_ex,
  output logic              dest_we_2_ex,
  output logic              halted
);
  typedef enum logic [1:0] {RUN, STALL, HALTED} state_t;
  localparam logic [5:0] OP_LDW  = 6'h0C;
  localparam logic [5:0] OP_STW  = 6'h0D;
  localparam logic [5:0] OP_BZ   = 6'h0E;
  localparam logic [5:0] OP_BEQ  = 6'h0F;
  localparam logic [5:0] OP_JR   = 6'h10;
  localparam logic [5:0] OP_HALT = 6'h11;

  logic [DATA_W-1:0] rf_q [NREG];
  state_t            state_q, state_d;
  logic              ex_valid_q, ex_valid_d;
  logic [5:0]        opc_q, opc_d;
  logic [DATA_W-1:0] rs_val_q, rs_val_d, rt_val_q, rt_val_d, imm_q, imm_d;
  logic [AW-1:0]     dest_q, dest_d;
  logic              dest_we_q, dest_we_d, halted_q, halted_d;

  logic [5:0]        op;
  logic [AW-1:0]     rs_i, rt_i, rd_i, dst;
  logic [DATA_W-1:0] rs_v, rt_v, imm_sx;
  logic              r_type, i_alu, is_ldw, is_halt, nop, wr_class, use_rs, use_rt;
  logic              hz, adv;

  assign op      = inst[31:26];
  assign rs_i    = inst[21 +: AW];
  assign rt_i    = inst[16 +: AW];
  assign rd_i    = inst[11 +: AW];
  assign r_type  = op <= 6'h0A && !op[0];
  assign i_alu   = op <= 6'h0B && op[0];
  assign is_ldw  = op == OP_LDW;
  assign is_halt = op == OP_HALT;
  assign nop     = op > OP_HALT;
  assign wr_class = r_type || i_alu || is_ldw;
  // Non-writing instructions carry dest 0 so EX never sees a stale index.
  assign dst     = !wr_class ? '0 : r_type ? rd_i : rt_i;
  assign use_rt  = r_type || op == OP_STW || op == OP_BEQ;
  assign use_rs  = use_rt || i_alu || is_ldw || op == OP_BZ || op == OP_JR;
  assign imm_sx  = (r_type || nop) ? '0 : DATA_W'($signed(inst[IMM_W-1:0]));

  // Same-cycle WB write-through; R0 is hard zero regardless of writes.
  assign rs_v = rs_i == '0 ? '0 : (wb_we && wb_addr == rs_i) ? wb_data : rf_q[rs_i];
  assign rt_v = rt_i == '0 ? '0 : (wb_we && wb_addr == rt_i) ? wb_data : rf_q[rt_i];

  // dest_we_q already implies dest_q != 0, so R0 sources never trigger a stall.
  assign hz  = if_valid && ex_valid_q && opc_q == OP_LDW && dest_we_q &&
               ((use_rs && dest_q == rs_i) || (use_rt && dest_q == rt_i));
  assign adv = !ex_valid_q || ex_ready;
  assign id_ready = flush || (state_q == RUN && adv && !hz);

  always_comb begin
    state_d    = state_q;
    ex_valid_d = ex_valid_q;
    opc_d      = opc_q;
    rs_val_d   = rs_val_q;
    rt_val_d   = rt_val_q;
    imm_d      = imm_q;
    dest_d     = dest_q;
    dest_we_d  = dest_we_q;
    halted_d   = halted_q;
    if (flush) begin
      ex_valid_d = 1'b0;
      state_d    = state_q == HALTED ? HALTED : RUN;
    end else if (state_q == RUN) begin
      if (if_valid && id_ready) begin
        ex_valid_d = 1'b1;
        opc_d      = op;
        rs_val_d   = rs_v;
        rt_val_d   = rt_v;
        imm_d      = imm_sx;
        dest_d     = dst;
        dest_we_d  = wr_class && dst != '0;
        state_d    = is_halt ? HALTED : RUN;
        halted_d   = halted_q || is_halt;
      end else if (adv) begin
        ex_valid_d = 1'b0;
        state_d    = hz ? STALL : RUN;
      end
    end else begin
      ex_valid_d = adv ? 1'b0 : ex_valid_q;
      state_d    = state_q == STALL ? RUN : state_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      ex_valid_q <= 1'b0;
      opc_q      <= '0;
      rs_val_q   <= '0;
      rt_val_q   <= '0;
      imm_q      <= '0;
      dest_q     <= '0;
      dest_we_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ex_valid_q <= ex_valid_d;
      opc_q      <= opc_d;
      rs_val_q   <= rs_val_d;
      rt_val_q   <= rt_val_d;
      imm_q      <= imm_d;
      dest_q     <= dest_d;
      dest_we_q  <= dest_we_d;
      halted_q   <= halted_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign opcode_2_ex  = opc_q;
  assign rs_val_2_ex  = rs_val_q;
  assign rt_val_2_ex  = rt_val_q;
  assign imm_2_ex     = imm_q;
  assign dest_2_ex    = dest_q;
  assign dest_we_2_ex = dest_we_q;
  assign halted       = halted_q;
endmodule

// File: tb/tb_id_stage_hz.sv
// tb_id_stage_hz: directed vector bench for id_stage_hz
module tb_id_stage_hz;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] inst = '0;
  logic        id_ready;
  logic        flush = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        ex_ready = 1'b1;
  logic        ex_valid;
  logic [5:0]  opcode_2_ex;
  logic [31:0] rs_val_2_ex, rt_val_2_ex, imm_2_ex;
  logic [4:0]  dest_2_ex;
  logic        dest_we_2_ex, halted;
  int total = 0;
  int bad = 0;

  id_stage_hz dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .inst(inst), .id_ready(id_ready),
    .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .opcode_2_ex(opcode_2_ex),
    .rs_val_2_ex(rs_val_2_ex), .rt_val_2_ex(rt_val_2_ex), .imm_2_ex(imm_2_ex),
    .dest_2_ex(dest_2_ex), .dest_we_2_ex(dest_we_2_ex), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] inst;
    logic [5:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        we;
  } vec_t;
  vec_t vec [12];

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] lo);
    return {op, rs, rt, lo};
  endfunction

  function automatic logic [15:0] rd(input logic [4:0] r);
    return {r, 11'b0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, mk(6'h00, 5'd5, 5'd5, rd(5'd3)),    6'h00, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        5'd3, 1'b1};
    vec[1]  = '{1'b0, 5'd0, 32'h0,        mk(6'h01, 5'd5, 5'd2, 16'h8001),    6'h01, 32'hDEADBEEF, 32'h0,        32'hFFFF8001, 5'd2, 1'b1};
    vec[2]  = '{1'b0, 5'd0, 32'h0,        mk(6'h01, 5'd0, 5'd2, 16'h7FFF),    6'h01, 32'h0,        32'h0,        32'h00007FFF, 5'd2, 1'b1};
    vec[3]  = '{1'b1, 5'd0, 32'h1234,     mk(6'h00, 5'd0, 5'd0, rd(5'd1)),    6'h00, 32'h0,        32'h0,        32'h0,        5'd1, 1'b1};
    vec[4]  = '{1'b0, 5'd0, 32'h0,        mk(6'h00, 5'd0, 5'd0, rd(5'd1)),    6'h00, 32'h0,        32'h0,        32'h0,        5'd1, 1'b1};
    vec[5]  = '{1'b0, 5'd0, 32'h0,        mk(6'h03, 5'd0, 5'd0, 16'h0005),    6'h03, 32'h0,        32'h0,        32'h5,        5'd0, 1'b0};
    vec[6]  = '{1'b1, 5'd7, 32'h1111,     mk(6'h0F, 5'd5, 5'd7, 16'hFFFF),    6'h0F, 32'hDEADBEEF, 32'h1111,     32'hFFFFFFFF, 5'd0, 1'b0};
    vec[7]  = '{1'b0, 5'd0, 32'h0,        mk(6'h0D, 5'd7, 5'd5, 16'h0010),    6'h0D, 32'h1111,     32'hDEADBEEF, 32'h10,       5'd0, 1'b0};
    vec[8]  = '{1'b0, 5'd0, 32'h0,        mk(6'h12, 5'd5, 5'd7, 16'h1234),    6'h12, 32'hDEADBEEF, 32'h1111,     32'h0,        5'd0, 1'b0};
    vec[9]  = '{1'b0, 5'd0, 32'h0,        mk(6'h02, 5'd5, 5'd7, rd(5'd9)),    6'h02, 32'hDEADBEEF, 32'h1111,     32'h0,        5'd9, 1'b1};
    vec[10] = '{1'b0, 5'd0, 32'h0,        mk(6'h0C, 5'd7, 5'd8, 16'hFFFC),    6'h0C, 32'h1111,     32'h0,        32'hFFFFFFFC, 5'd8, 1'b1};
    vec[11] = '{1'b0, 5'd0, 32'h0,        mk(6'h10, 5'd5, 5'd0, 16'h0000),    6'h10, 32'hDEADBEEF, 32'h0,        32'h0,        5'd0, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset ex_valid", ex_valid, 0);
    chk("reset halted", halted, 0);
    chk("reset opcode", opcode_2_ex, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle id_ready", id_ready, 1);

    for (int i = 0; i < 12; i++) begin
      wb_we = vec[i].wb_we; wb_addr = vec[i].wb_addr; wb_data = vec[i].wb_data;
      inst = vec[i].inst; if_valid = 1'b1;
      #1 chk($sformatf("v%0d id_ready", i), id_ready, 1);
      step();
      wb_we = 1'b0;
      chk($sformatf("v%0d ex_valid", i), ex_valid, 1);
      chk($sformatf("v%0d fields", i),
          {opcode_2_ex, dest_2_ex, dest_we_2_ex, imm_2_ex},
          {vec[i].op, vec[i].dest, vec[i].we, vec[i].imm});
      chk($sformatf("v%0d operands", i), {rs_val_2_ex, rt_val_2_ex}, {vec[i].rs, vec[i].rt});
    end

    inst = mk(6'h0C, 5'd0, 5'd4, 16'h0);
    step();
    inst = mk(6'h00, 5'd4, 5'd1, rd(5'd6));
    #1 chk("lu hz id_ready", id_ready, 0);
    chk("lu ldw in ex", opcode_2_ex, 6'h0C);
    step();
    chk("lu bubble", ex_valid, 0);
    chk("lu stall id_ready", id_ready, 0);
    step();
    chk("lu resume id_ready", id_ready, 1);
    step();
    chk("lu add issued", {ex_valid, opcode_2_ex, dest_2_ex}, {1'b1, 6'h00, 5'd6});

    inst = mk(6'h0C, 5'd0, 5'd4, 16'h0);
    step();
    inst = mk(6'h00, 5'd1, 5'd2, rd(5'd6));
    #1 chk("nolu id_ready", id_ready, 1);
    step();
    chk("nolu add issued", {ex_valid, opcode_2_ex, dest_2_ex}, {1'b1, 6'h00, 5'd6});

    ex_ready = 1'b0;
    inst = mk(6'h01, 5'd5, 5'd2, 16'h0042);
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("bp%0d id_ready", c), id_ready, 0);
      chk($sformatf("bp%0d hold", c), {ex_valid, opcode_2_ex, dest_2_ex, imm_2_ex}, {1'b1, 6'h00, 5'd6, 32'h0});
      step();
    end
    ex_ready = 1'b1;
    #1 chk("bp release id_ready", id_ready, 1);
    step();
    chk("bp next", {ex_valid, opcode_2_ex, dest_2_ex, rs_val_2_ex, imm_2_ex},
        {1'b1, 6'h01, 5'd2, 32'hDEADBEEF, 32'h42});

    inst = mk(6'h11, 5'd0, 5'd0, 16'h0);
    flush = 1'b1;
    #1 chk("flush id_ready", id_ready, 1);
    step();
    flush = 1'b0;
    if_valid = 1'b0;
    chk("flush halt", {ex_valid, halted}, 2'b00);
    #1 chk("flush run id_ready", id_ready, 1);

    if_valid = 1'b1;
    step();
    chk("halt issued", {halted, ex_valid, opcode_2_ex}, {1'b1, 1'b1, 6'h11});
    inst = mk(6'h00, 5'd5, 5'd5, rd(5'd3));
    #1 chk("halted id_ready", id_ready, 0);
    step();
    chk("halted drained", {halted, ex_valid}, 2'b10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush while halted", halted, 1);
    #1 chk("halted id_ready 2", id_ready, 0);

    #1 reset = 1'b0;
    #1 chk("async reset", {halted, ex_valid, opcode_2_ex}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("post reset id_ready", id_ready, 1);
    step();
    chk("rf cleared", {ex_valid, rs_val_2_ex, rt_val_2_ex, dest_2_ex}, {1'b1, 32'h0, 32'h0, 5'd3});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
